// File: rtl/pci_bus_arbiter.sv
// Round-robin central arbiter for a shared PCI-style bus, with hidden arbitration and unused-grant revocation.
// Latency: a request sampled on an idle bus is granted after one clk edge; all outputs are registered.
// Backpressure: none; devices are throttled by the grant itself, and a grant idle for TIMEOUT cycles is revoked.
module pci_bus_arbiter #(
  parameter int NUM_MASTERS = 4,
  parameter int TIMEOUT     = 16,
  parameter int ID_W        = $clog2(NUM_MASTERS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_MASTERS-1:0] req_n,
  input  logic                   frame_n,
  input  logic                   irdy_n,
  output logic [NUM_MASTERS-1:0] gnt_n,
  output logic [ID_W-1:0]        owner_id,
  output logic                   owner_valid,
  output logic                   timeout
);

  localparam int                 TIMER_W    = 5;
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GRANT,
    ST_BUSY
  } state_t;

  state_t                 state;
  logic [ID_W-1:0]        last;      // most recent owner (or revoked master); search starts after it
  logic [ID_W-1:0]        sel;       // master currently holding the grant line
  logic [TIMER_W-1:0]     timer;     // idle-bus cycles spent in GRANT
  logic                   pending;   // a grant is parked on a master while the bus is busy

  logic                   bus_idle;
  logic                   sel_withdrawn;
  logic [NUM_MASTERS-1:0] cand;
  logic [NUM_MASTERS-1:0] cand_rot;
  int                     start_pos;
  logic                   win_found;
  logic [ID_W-1:0]        win_idx;

  assign bus_idle      = frame_n & irdy_n;
  assign sel_withdrawn = req_n[sel];

  // Active-low one-hot grant pattern for a single master index.
  function automatic logic [NUM_MASTERS-1:0] grant_vec(input logic [ID_W-1:0] idx);
    grant_vec = ~(NUM_MASTERS'(1) << idx);
  endfunction

  // Candidate requesters; the current owner never wins hidden arbitration for its own transfer.
  always_comb begin
    cand = ~req_n;
    if (state == ST_BUSY && owner_valid) begin
      cand[owner_id] = 1'b0;
    end
  end

  // Round-robin pick: rotate candidates so the slot after 'last' sits at bit 0, then take the lowest set bit.
  always_comb begin
    start_pos = (int'(last) + 1) % NUM_MASTERS;
    cand_rot  = NUM_MASTERS'({cand, cand} >> start_pos);
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      if (!win_found && cand_rot[k]) begin
        win_found = 1'b1;
        win_idx   = ID_W'((start_pos + k) % NUM_MASTERS);
      end
    end
  end

  // Arbitration FSM with registered grant, ownership and timeout outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      gnt_n       <= '1;
      owner_id    <= '0;
      owner_valid <= 1'b0;
      timeout     <= 1'b0;
      last        <= ID_W'(NUM_MASTERS - 1);
      sel         <= '0;
      timer       <= '0;
      pending     <= 1'b0;
    end else begin
      timeout <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (win_found) begin
            gnt_n <= grant_vec(win_idx);
            sel   <= win_idx;
            if (bus_idle) begin
              timer <= '0;
              state <= ST_GRANT;
            end else begin
              // Leftover or foreign traffic: park the grant until the bus frees up.
              pending <= 1'b1;
              state   <= ST_BUSY;
            end
          end
        end

        ST_GRANT: begin
          if (!frame_n) begin
            // Master has started its transaction; drop the grant so another can be parked.
            state       <= ST_BUSY;
            owner_id    <= sel;
            owner_valid <= 1'b1;
            last        <= sel;
            gnt_n       <= '1;
            pending     <= 1'b0;
          end else if (sel_withdrawn) begin
            state <= ST_IDLE;
            gnt_n <= '1;
          end else if (timer == TIMER_LAST) begin
            // Unused grant: revoke and push this master to the back of the rotation.
            state   <= ST_IDLE;
            gnt_n   <= '1;
            last    <= sel;
            timeout <= 1'b1;
          end else begin
            timer <= timer + 1'b1;
          end
        end

        ST_BUSY: begin
          if (pending && sel_withdrawn) begin
            // Parked master gave up; free the line and re-arbitrate no earlier than next cycle.
            pending <= 1'b0;
            gnt_n   <= '1;
            if (bus_idle) begin
              owner_valid <= 1'b0;
              state       <= ST_IDLE;
            end
          end else if (bus_idle) begin
            owner_valid <= 1'b0;
            if (pending) begin
              // Parked grant is kept and becomes a normal grant on the now-idle bus.
              pending <= 1'b0;
              timer   <= '0;
              state   <= ST_GRANT;
            end else begin
              state <= ST_IDLE;
            end
          end else if (!pending && win_found) begin
            // Hidden arbitration: the winner is locked until it is used or withdrawn.
            gnt_n   <= grant_vec(win_idx);
            sel     <= win_idx;
            pending <= 1'b1;
          end
        end

        default: begin
          state   <= ST_IDLE;
          gnt_n   <= '1;
          pending <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/pci_bus_arbiter.md
# pci_bus_arbiter

Central arbiter for the shared PCI-style bus. It samples each device's active-low request line and issues one active-low grant at a time, using round-robin priority. It watches the shared FRAME/IRDY lines to track bus ownership. It sits directly upstream of every bus device: its `gnt_n[i]` drives the device's `GNT` input, and the device's `req` output drives `req_n[i]`. It supports hidden arbitration during a transfer and revokes a grant that the granted master never uses.

## Interface
- `NUM_MASTERS`, default 4: number of devices; legal range 2..16.
- `TIMEOUT`, default 16: number of idle-bus GRANT cycles allowed before an unused grant is revoked; legal range 2..31.
- `ID_W`, default `$clog2(NUM_MASTERS)`: width of `owner_id`.

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  bus clock; all state updates on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req_n`  in  NUM_MASTERS  per-device request, active low.
- `frame_n`  in  1  shared bus FRAME (the devices' `GLOBAL_FRAME`), active low.
- `irdy_n`  in  1  shared bus IRDY (the devices' `GLOBAL_IRDY`), active low.
- `gnt_n`  out  NUM_MASTERS  per-device grant, active low; at most one bit low at any time.
- `owner_id`  out  ID_W  index of the master that owns the current transaction.
- `owner_valid`  out  1  high while a granted master's transaction is in progress.
- `timeout`  out  1  one-cycle pulse when a grant is revoked for non-use.

## Operation
- The bus is idle when `frame_n & irdy_n` is 1.
- The round-robin pointer is `last`. The search starts at `(last+1) mod NUM_MASTERS` and selects the first index with `req_n` low. `last` resets to NUM_MASTERS-1, so master 0 has first priority out of reset.
- **IDLE**: `gnt_n` is all ones.
  - Any request and bus idle: assert the winner's grant, capture `sel`, clear `timer`, go to GRANT.
  - Any request and bus busy (foreign or leftover traffic): assert the winner's grant, go to BUSY with a pending grant.
- **GRANT**: the winner's grant is held.
  - `frame_n`=0 sampled: go to BUSY. Set `owner_id`=`sel`, `owner_valid`=1, `last`=`sel`, `gnt_n`=all ones.
  - Else `req_n[sel]`=1 (request withdrawn): go to IDLE, grant released.
  - Else `timer`==TIMEOUT-1: go to IDLE, grant released, `last`=`sel` (skip that master), `timeout`=1 for one cycle.
  - Otherwise: `timer` increments.
- **BUSY**: a transaction is in progress.
  - No pending grant and some other request exists: do hidden arbitration. Assert the winner's grant and lock `sel`; a locked pending grant is not re-evaluated.
  - Pending master withdraws its request: release the grant; arbitration is allowed again the following cycle.
  - Bus idle sampled:
    - Pending grant exists: go to GRANT with the grant still held, `timer`=0.
    - No pending grant: go to IDLE.
    - In both cases `owner_valid` drops.
- `owner_id` holds its last value when `owner_valid`=0.

## Timing
- All outputs are registered. Reset values: `gnt_n`=all ones, `owner_id`=0, `owner_valid`=0, `timeout`=0, state IDLE, `last`=NUM_MASTERS-1, `timer`=0.
- Grant latency: a request sampled at edge k in IDLE gives `gnt_n` low after edge k (visible in cycle k+1).
- `frame_n` low sampled at edge k in GRANT: grant is high and `owner_valid` is high after edge k.
- Precedence when events coincide in GRANT: frame assertion, then request withdrawal, then timeout.
- Never two grant bits low at once. Moving a grant between masters always passes through at least one all-ones cycle.
- Timer width: 5 bits. The timer counts only in GRANT.
- `rst` asserted at any time, including mid-BUSY: outputs go to their reset values immediately, without waiting for a clock edge. Arbitration resumes at the first edge after `rst` deasserts.

## Test plan
- **Reset**: assert `rst` mid-transfer with `req_n`=4'b0000 → `gnt_n`=4'b1111, `owner_valid`=0, `timeout`=0 immediately. First grant after release goes to master 0.
- **Single request**: bus idle, `req_n`=4'b1110 → `gnt_n`=4'b1110 next cycle. Drive `frame_n`=0 → after the next edge `gnt_n`=4'b1111, `owner_valid`=1, `owner_id`=0.
- **Round-robin**: `req_n`=4'b0000 held, each master runs a 3-cycle transfer → grant order 0,1,2,3,0.
- **Hidden arbitration**: master 0 in BUSY, then `req_n[1]`=0 → `gnt_n`=4'b1101 while `frame_n`=0. Bus goes idle → GRANT with the same grant held and `owner_valid`=0.
- **Timeout**: master 2 granted on an idle bus, never drives FRAME → after 16 GRANT cycles `gnt_n`=4'b1111 and `timeout`=1 for one cycle. With `req_n`=4'b0011, the next grant is `gnt_n`=4'b0111 (master 3).
- **Simultaneous**: in the GRANT cycle where `timer`=TIMEOUT-1, `frame_n`=0 and `req_n[sel]`=1 → BUSY with `owner_valid`=1 and no `timeout` pulse.
